// File: rtl/axis_frame_gen.sv
// AXI4-Stream source emitting incrementing-byte frames of programmable length, seed and tdest.
// Registered outputs; first beat one cycle after command accept; beats held stable while tready is low.
module axis_frame_gen #(
  parameter int DATA_WIDTH  = 64,
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int LEN_WIDTH   = 16,
  parameter int DEST_WIDTH  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic [7:0]             cmd_seed,
  input  logic [DEST_WIDTH-1:0]  cmd_dest,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [DEST_WIDTH-1:0]  m_axis_tdest,
  output logic                   m_axis_tuser,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [LEN_WIDTH-1:0] KW_LEN = LEN_WIDTH'(KEEP_WIDTH);

  state_t                 state, state_nxt;
  logic [LEN_WIDTH-1:0]   rem, rem_nxt;
  logic [7:0]             base, base_nxt;
  logic [DATA_WIDTH-1:0]  tdata_nxt;
  logic [KEEP_WIDTH-1:0]  tkeep_nxt;
  logic                   tvalid_nxt, tlast_nxt;
  logic [DEST_WIDTH-1:0]  tdest_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;

  logic [7:0]             src_base;
  logic [LEN_WIDTH-1:0]   src_len;
  logic [DATA_WIDTH-1:0]  beat_data;
  logic [KEEP_WIDTH-1:0]  beat_keep;
  logic                   beat_last;
  logic [LEN_WIDTH-1:0]   beat_rem;

  // rem counts bytes still to be presented after the current beat, so the
  // maximum length never needs a wider counter.
  always_comb begin
    src_base  = (state == IDLE) ? cmd_seed : base;
    src_len   = (state == IDLE) ? cmd_len  : rem;
    beat_data = '0;
    beat_keep = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      beat_data[8*j +: 8] = src_base + 8'(j);
      beat_keep[j]        = (src_len >= KW_LEN) || (LEN_WIDTH'(j) < src_len);
    end
    beat_last = (src_len <= KW_LEN);
    beat_rem  = beat_last ? '0 : (src_len - KW_LEN);
  end

  always_comb begin
    state_nxt  = state;
    rem_nxt    = rem;
    base_nxt   = base;
    tdata_nxt  = m_axis_tdata;
    tkeep_nxt  = m_axis_tkeep;
    tvalid_nxt = m_axis_tvalid;
    tlast_nxt  = m_axis_tlast;
    tdest_nxt  = m_axis_tdest;
    count_nxt  = frame_count;
    case (state)
      IDLE: begin
        if (cmd_valid && (cmd_len != '0)) begin
          state_nxt  = SEND;
          tdest_nxt  = cmd_dest;
          tvalid_nxt = 1'b1;
          tdata_nxt  = beat_data;
          tkeep_nxt  = beat_keep;
          tlast_nxt  = beat_last;
          rem_nxt    = beat_rem;
          base_nxt   = src_base + 8'(KEEP_WIDTH);
        end
      end
      SEND: begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (m_axis_tlast) begin
            state_nxt  = IDLE;
            tvalid_nxt = 1'b0;
            tlast_nxt  = 1'b0;
            count_nxt  = frame_count + COUNT_WIDTH'(1);
          end else begin
            tdata_nxt  = beat_data;
            tkeep_nxt  = beat_keep;
            tlast_nxt  = beat_last;
            rem_nxt    = beat_rem;
            base_nxt   = src_base + 8'(KEEP_WIDTH);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rem           <= '0;
      base          <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
      frame_count   <= '0;
    end else begin
      state         <= state_nxt;
      rem           <= rem_nxt;
      base          <= base_nxt;
      m_axis_tdata  <= tdata_nxt;
      m_axis_tkeep  <= tkeep_nxt;
      m_axis_tvalid <= tvalid_nxt;
      m_axis_tlast  <= tlast_nxt;
      m_axis_tdest  <= tdest_nxt;
      frame_count   <= count_nxt;
    end
  end

  assign cmd_ready    = (state == IDLE);
  assign busy         = (state == SEND);
  assign m_axis_tuser = 1'b0;

endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomised and directed checks of axis_frame_gen against a frame-level reference model.
module tb_axis_frame_gen;

  localparam int DW = 64;
  localparam int KW = 8;

  logic           clk;
  logic           rst;
  logic [15:0]    cmd_len;
  logic [7:0]     cmd_seed;
  logic [7:0]     cmd_dest;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           m_axis_tlast;
  logic [7:0]     m_axis_tdest;
  logic           m_axis_tuser;
  logic           busy;
  logic [31:0]    frame_count;

  axis_frame_gen dut (
    .clk(clk), .rst(rst),
    .cmd_len(cmd_len), .cmd_seed(cmd_seed), .cmd_dest(cmd_dest),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
    .m_axis_tuser(m_axis_tuser), .busy(busy), .frame_count(frame_count)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  dest;
  } beat_t;

  beat_t       m_q[$];
  beat_t       got[$];
  bit          m_busy  = 1'b0;
  logic [7:0]  m_dest  = '0;
  logic [31:0] m_count = '0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en  = 1'b0;
  bit          rnd_rdy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: a frame is just a list of beats computed from the byte rule.
  task automatic build_frame(input int len, input int seed, input logic [7:0] dest);
    int nb;
    int r;
    beat_t b;
    nb = (len + KW - 1) / KW;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < KW; j++) b.data[8*j +: 8] = 8'((seed + k*KW + j) % 256);
      r      = len % KW;
      b.last = (k == nb - 1);
      b.keep = (b.last && r != 0) ? 8'((1 << r) - 1) : 8'hFF;
      b.dest = dest;
      m_q.push_back(b);
    end
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  initial begin
    beat_t e;
    beat_t g;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("cmd_ready", cmd_ready, !m_busy);
        chk("busy", busy, m_busy);
        chk("tvalid", m_axis_tvalid, m_busy);
        chk("tuser", m_axis_tuser, 0);
        chk("frame_count", frame_count, m_count);
        if (m_busy && m_q.size() > 0) begin
          e = m_q[0];
          chk("tdata", m_axis_tdata, e.data);
          chk("tkeep", m_axis_tkeep, e.keep);
          chk("tlast", m_axis_tlast, e.last);
          chk("tdest", m_axis_tdest, e.dest);
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
          g.data = m_axis_tdata; g.keep = m_axis_tkeep;
          g.last = m_axis_tlast; g.dest = m_axis_tdest;
          got.push_back(g);
        end
      end
      if (rst) begin
        m_busy = 1'b0; m_q.delete(); m_count = '0;
      end else if (!m_busy) begin
        if (cmd_valid && cmd_len != 0) begin
          m_dest = cmd_dest;
          build_frame(int'(cmd_len), int'(cmd_seed), cmd_dest);
          m_busy = 1'b1;
        end
      end else if (m_axis_tready && m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e.last) begin
          m_busy  = 1'b0;
          m_count = m_count + 1;
        end
      end
    end
  end

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input int budget);
    int c = 0;
    while (cmd_ready !== 1'b1 && c < budget) begin
      step(1);
      c++;
    end
    chk("wait_ready_timeout", (c >= budget), 0);
  endtask

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic [7:0] dest);
    wait_ready(20000);
    cmd_len   = 16'(len);
    cmd_seed  = seed;
    cmd_dest  = dest;
    cmd_valid = 1'b1;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic run_frame(input int len, input logic [7:0] seed, input logic [7:0] dest);
    got.delete();
    send_cmd(len, seed, dest);
    wait_ready(20000);
  endtask

  initial begin
    int c;
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0; cmd_dest = '0;
    step(2);
    chk_en = 1'b1;
    step(1);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tkeep", m_axis_tkeep, 0);
    chk("rst_tdest", m_axis_tdest, 0);
    rst = 1'b0;
    step(1);

    run_frame(20, 8'h10, 8'd3);
    chk("f20_beats", got.size(), 3);
    if (got.size() == 3) begin
      chk("f20_b0_data", got[0].data, 64'h17161514_13121110);
      chk("f20_b0_keep", got[0].keep, 8'hFF);
      chk("f20_b2_data_lo", got[2].data[31:0], 32'h23222120);
      chk("f20_b2_keep", got[2].keep, 8'h0F);
      chk("f20_b2_last", got[2].last, 1);
      for (int i = 0; i < 3; i++) chk("f20_dest", got[i].dest, 8'd3);
    end
    chk("f20_count", frame_count, 1);

    run_frame(16, 8'h00, 8'd1);
    chk("f16_beats", got.size(), 2);
    if (got.size() == 2) begin
      chk("f16_b1_keep", got[1].keep, 8'hFF);
      chk("f16_b1_last", got[1].last, 1);
      chk("f16_b0_last", got[0].last, 0);
    end
    run_frame(1, 8'h42, 8'd2);
    chk("f1_beats", got.size(), 1);
    if (got.size() == 1) begin
      chk("f1_keep", got[0].keep, 8'h01);
      chk("f1_last", got[0].last, 1);
    end
    run_frame(8, 8'hFC, 8'd4);
    chk("fwrap_beats", got.size(), 1);
    if (got.size() == 1) begin
      chk("fwrap_data", got[0].data, 64'h03020100_FFFEFDFC);
      chk("fwrap_keep", got[0].keep, 8'hFF);
      chk("fwrap_last", got[0].last, 1);
    end

    // Stalled frame with a stray command offered while busy.
    got.delete();
    rnd_rdy = 1'b1;
    send_cmd(100, 8'h33, 8'd9);
    cmd_len = 16'd5; cmd_seed = 8'hEE; cmd_dest = 8'd1; cmd_valid = 1'b1;
    step(4);
    cmd_valid = 1'b0;
    wait_ready(20000);
    rnd_rdy = 1'b0;
    chk("f100_beats", got.size(), 13);
    if (got.size() == 13) begin
      chk("f100_last_keep", got[12].keep, 8'h0F);
      chk("f100_last_data_lo", got[12].data[31:0], 32'h96959493);
    end
    chk("f100_count", frame_count, 5);

    run_frame(0, 8'h00, 8'd0);
    step(5);
    chk("f0_beats", got.size(), 0);
    chk("f0_count", frame_count, 5);
    chk("f0_cmd_ready", cmd_ready, 1);

    // Reset in the middle of a frame.
    got.delete();
    send_cmd(40, 8'h00, 8'd6);
    c = 0;
    while (got.size() < 2 && c < 100) begin
      step(1);
      c++;
    end
    chk("mid_rst_wait_timeout", (c >= 100), 0);
    rst = 1'b1;
    step(1);
    chk("mid_rst_tvalid", m_axis_tvalid, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_count", frame_count, 0);
    rst = 1'b0;
    step(1);
    run_frame(8, 8'hA0, 8'd5);
    chk("post_rst_beats", got.size(), 1);
    if (got.size() == 1) begin
      chk("post_rst_data", got[0].data, 64'hA7A6A5A4_A3A2A1A0);
      chk("post_rst_keep", got[0].keep, 8'hFF);
      chk("post_rst_last", got[0].last, 1);
    end

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int len;
      len = ($urandom % 4 == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(1, 200));
      run_frame(len, 8'($urandom), 8'($urandom));
      chk("rand_beats", got.size(), (len + KW - 1) / KW);
      step(int'($urandom_range(0, 3)));
    end
    rnd_rdy = 1'b0;

    run_frame(65535, 8'h5A, 8'h77);
    chk("max_beats", got.size(), 8192);
    if (got.size() == 8192) begin
      chk("max_last_keep", got[8191].keep, 8'h7F);
      chk("max_last_last", got[8191].last, 1);
      chk("max_last_byte0", got[8191].data[7:0], 8'h52);
    end
    step(3);
    chk("model_drained", m_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
